tlc_phase_scheduler: RTL and testbench
======================================

Name: tlc_phase_scheduler

Overview:
- Demand-actuated phase scheduler for the four-approach intersection; drives the four 3-bit signal heads (light_m1..light_m4).
- Latches vehicle detector requests, grants green to one approach at a time in round-robin order, enforces min/max green, yellow and all-red clearance.
- All timing is counted in ticks of an external 1-per-second enable (tick), so the block runs on the fast system clock.

Parameters:
- TW, 8, timer width in bits.
- MIN_GREEN, 5, minimum green in ticks (>=1).
- MAX_GREEN, 30, maximum green in ticks when a conflicting request is pending (>= MIN_GREEN).
- YELLOW_T, 3, yellow duration in ticks (>=1).
- ALL_RED_T, 2, all-red clearance in ticks (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle timing enable; all timers advance only on cycles with tick=1.
- req  input  4  detector requests; bit i corresponds to approach m(i+1); a one-cycle pulse is sufficient.
- light_m1..light_m4  output  3 each  signal head {R,Y,G}: 3'b100 red, 3'b010 yellow, 3'b001 green.
- phase  output  2  index of the approach currently green or yellow, or the last one served.
- busy_clear  output  1  high during yellow and all-red.

Behaviour:
- Reset (reset=0, async): state INIT_RED; all lights 3'b100; phase=0; pending=0; timer=0; busy_clear=1.
- Registers and outputs:
  - pending[3:0] is set by req[i] on any cycle.
  - pending[i] is cleared on the cycle approach i enters GREEN; a set and a clear on the same cycle resolve to clear.
  - All outputs are registered and decoded from state and phase, with no combinational path from inputs.
- Timer:
  - Cleared on every state entry; increments on tick.
  - A state of length L exits on the clock edge where tick=1 and timer==L-1, so the state lasts exactly L ticks.
- INIT_RED: lasts ALL_RED_T ticks, then GREEN with phase=0 (resting approach).
- GREEN: light_m(phase+1)=001; others 100. "other" = pending bits excluding phase. Exit to YELLOW on a tick edge when any of:
  - timer>=MIN_GREEN-1, other!=0 and pending[phase]==0 (gap-out);
  - timer>=MAX_GREEN-1 and other!=0 (max-out).
- GREEN with other==0:
  - Rests on green indefinitely.
  - Timer saturates at its all-ones value; it does not wrap.
- YELLOW entry: next approach is latched as the first set bit of other, searching phase+1, phase+2, phase+3 (mod 4). light_m(phase+1)=010 for YELLOW_T ticks, then ALL_RED.
- ALL_RED: all 100 for ALL_RED_T ticks, then GREEN with phase=next.
- Requests arriving during YELLOW or ALL_RED are latched but do not alter the already-latched next approach.
- No two heads are ever simultaneously non-red.
- Reset asserted mid-operation returns immediately to the reset state, regardless of state.

Optional Feature:
- Macro TLC_EMERGENCY_PREEMPT_EN.
- Defined: ports emerg_valid (1, input) and emerg_dir (2, input) are added.
  - While emerg_valid=1 and state==GREEN with phase!=emerg_dir: exit to YELLOW on the next tick edge, ignoring MIN_GREEN. next is forced to emerg_dir.
  - During YELLOW or ALL_RED, next is overwritten with emerg_dir.
  - In GREEN with phase==emerg_dir and emerg_valid=1, green is held and MAX_GREEN is ignored.
  - On deassertion, normal rules resume with the timer value retained.
- Undefined: the ports do not exist and the behaviour is exactly as above.

Decomposition:
- Package tlc_pkg:
  - state enum {INIT_RED, GREEN, YELLOW, ALL_RED};
  - constants LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001.
- Sub-module tlc_rr_pick:
  - combinational 4-way rotating-priority picker;
  - inputs: mask[3:0], start[1:0];
  - outputs: valid, idx[1:0].

Test Plan:
All cases use MIN_GREEN=4, MAX_GREEN=10, YELLOW_T=2, ALL_RED_T=1, tick held at 1.
- Reset then no req -> 1 cycle all red, then light_m1=001 held for 50 cycles, busy_clear=0.
- req=4'b0100 pulse at cycle 3 of green, req[0] never set -> gap-out:
  - light_m1 green for 4 cycles, then 010 for 2, then all red for 1;
  - then light_m3=001, phase=2, pending[2]=0.
- req[0] held high with req[1] pulsed -> max-out: light_m1 green exactly 10 cycles, then yellow, then light_m2 green.
- pending=4'b1010 while phase=2 -> order is approach 3 (m4) then 1 (m2), confirming round-robin wrap.
- reset low during YELLOW -> all heads 100 on the same edge, pending=0, restart via INIT_RED.
- (macro defined) emerg_valid=1, emerg_dir=3 at green cycle 1 on m1:
  - m1 yellow on the next cycle, then m4 green held for 40 cycles;
  - after deassertion, normal scheduling resumes.

Source files
------------

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - scheduler states, signal-head encodings and head decode helper
package tlc_pkg;

  typedef enum logic [1:0] {INIT_RED, GREEN, YELLOW, ALL_RED} state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Only the approach named by phase may show anything other than red.
  function automatic logic [2:0] head_color(state_t st, logic [1:0] ph, logic [1:0] idx);
    if (ph != idx) return LIGHT_RED;
    if (st == GREEN) return LIGHT_GRN;
    if (st == YELLOW) return LIGHT_YEL;
    return LIGHT_RED;
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// rtl/tlc_phase_scheduler_if.sv - timing, detector and signal-head bundle; TLC_EMERGENCY_PREEMPT_EN adds preempt inputs
interface tlc_phase_scheduler_if;
  logic       tick;
  logic [3:0] req;
  logic [2:0] light_m1;
  logic [2:0] light_m2;
  logic [2:0] light_m3;
  logic [2:0] light_m4;
  logic [1:0] phase;
  logic       busy_clear;
`ifdef TLC_EMERGENCY_PREEMPT_EN
  logic       emerg_valid;
  logic [1:0] emerg_dir;

  modport master (output tick, req, emerg_valid, emerg_dir,
                  input light_m1, light_m2, light_m3, light_m4, phase, busy_clear);
  modport slave (input tick, req, emerg_valid, emerg_dir,
                 output light_m1, light_m2, light_m3, light_m4, phase, busy_clear);
`else
  modport master (output tick, req,
                  input light_m1, light_m2, light_m3, light_m4, phase, busy_clear);
  modport slave (input tick, req,
                 output light_m1, light_m2, light_m3, light_m4, phase, busy_clear);
`endif
endinterface

// File: rtl/tlc_rr_pick.sv
// rtl/tlc_rr_pick.sv - 4-way rotating-priority picker, first set bit of mask at or after start
module tlc_rr_pick (
  input  logic [3:0] mask,
  input  logic [1:0] start,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (mask[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// rtl/tlc_phase_scheduler.sv - demand-actuated 4-approach phase scheduler; TLC_EMERGENCY_PREEMPT_EN enables preemption
module tlc_phase_scheduler #(
  parameter int TW        = 8,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2
) (
  input logic clk,
  input logic reset,
  tlc_phase_scheduler_if.slave bus
);
  import tlc_pkg::*;

  state_t          state, state_nx;
  logic [1:0]      phase, phase_nx;
  logic [1:0]      next_ph, next_nx, next_eff;
  logic [3:0]      pending, pending_nx, other;
  logic [TW-1:0]   timer, timer_nx;
  logic            pick_valid;
  logic [1:0]      pick_idx;
  logic            preempt, hold, gap_out, max_out;
  logic [2:0]      light_q [4];
  logic            busy_q;

  assign other = pending & ~(4'b0001 << phase);

  tlc_rr_pick u_pick (
    .mask  (other),
    .start (phase + 2'd1),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
`ifdef TLC_EMERGENCY_PREEMPT_EN
    preempt  = bus.emerg_valid && (bus.emerg_dir != phase);
    hold     = bus.emerg_valid && (bus.emerg_dir == phase);
    next_eff = bus.emerg_valid ? bus.emerg_dir : next_ph;
`else
    preempt  = 1'b0;
    hold     = 1'b0;
    next_eff = next_ph;
`endif
    gap_out  = pick_valid && (timer >= TW'(MIN_GREEN - 1)) && !pending[phase];
    max_out  = pick_valid && (timer >= TW'(MAX_GREEN - 1));
    state_nx = state;
    phase_nx = phase;
    next_nx  = next_ph;

    case (state)
      INIT_RED: begin
        if (bus.tick && timer == TW'(ALL_RED_T - 1)) begin
          state_nx = GREEN;
          phase_nx = 2'd0;
        end
      end
      GREEN: begin
        if (bus.tick && (preempt || (!hold && (gap_out || max_out)))) begin
          state_nx = YELLOW;
          next_nx  = preempt ? next_eff : pick_idx;
        end
      end
      YELLOW: begin
        next_nx = next_eff;
        if (bus.tick && timer == TW'(YELLOW_T - 1)) state_nx = ALL_RED;
      end
      ALL_RED: begin
        next_nx = next_eff;
        if (bus.tick && timer == TW'(ALL_RED_T - 1)) begin
          state_nx = GREEN;
          phase_nx = next_eff;
        end
      end
      default: state_nx = INIT_RED;
    endcase

    // Resting green may sit for an unbounded time, so the timer pins at all-ones.
    if (state_nx != state) timer_nx = '0;
    else if (bus.tick && timer != '1) timer_nx = timer + TW'(1);
    else timer_nx = timer;

    pending_nx = pending | bus.req;
    if (state_nx == GREEN && state != GREEN) pending_nx[phase_nx] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT_RED;
      phase   <= 2'd0;
      next_ph <= 2'd0;
      pending <= 4'd0;
      timer   <= '0;
      busy_q  <= 1'b1;
      for (int i = 0; i < 4; i++) light_q[i] <= LIGHT_RED;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      next_ph <= next_nx;
      pending <= pending_nx;
      timer   <= timer_nx;
      busy_q  <= (state_nx != GREEN);
      for (int i = 0; i < 4; i++) light_q[i] <= head_color(state_nx, phase_nx, 2'(i));
    end
  end

  assign bus.light_m1   = light_q[0];
  assign bus.light_m2   = light_q[1];
  assign bus.light_m3   = light_q[2];
  assign bus.light_m4   = light_q[3];
  assign bus.phase      = phase;
  assign bus.busy_clear = busy_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb/tb_tlc_phase_scheduler.sv - scoreboard bench for tlc_phase_scheduler; TLC_EMERGENCY_PREEMPT_EN adds the preempt case
module tb_tlc_phase_scheduler;

  typedef struct packed {
    logic [11:0] lights;
    logic [1:0]  phase;
    logic        busy;
  } exp_t;

  localparam logic [11:0] ALLR = 12'h924;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t exp_q [$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  tlc_phase_scheduler_if bus ();

  tlc_phase_scheduler #(
    .TW        (8),
    .MIN_GREEN (4),
    .MAX_GREEN (10),
    .YELLOW_T  (2),
    .ALL_RED_T (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] hd(input int idx, input logic [2:0] c);
    logic [11:0] v;
    v = ALLR;
    v[idx*3 +: 3] = c;
    return v;
  endfunction

  function automatic logic [11:0] g(input int idx);
    return hd(idx, 3'b001);
  endfunction

  function automatic logic [11:0] y(input int idx);
    return hd(idx, 3'b010);
  endfunction

  task automatic push(input logic [11:0] l, input logic [1:0] p, input logic b);
    exp_t e;
    e.lights = l;
    e.phase  = p;
    e.busy   = b;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [11:0] l, input logic [1:0] p, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      push(l, p, b);
    end
  endtask

  // Reset lands mid-cycle, so the very next sample must already show the reset state.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(ALLR, 2'd0, 1'b1);
    cyc(ALLR, 2'd0, 1'b1, 1);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t got;
      e = exp_q.pop_front();
      got.lights = {bus.light_m4, bus.light_m3, bus.light_m2, bus.light_m1};
      got.phase  = bus.phase;
      got.busy   = bus.busy_clear;
      vec_cnt++;
      if (got !== e) begin
        err_cnt++;
        $display("FAIL vec%0d lights got %h exp %h phase got %0d exp %0d busy got %b exp %b",
                 vec_cnt, got.lights, e.lights, got.phase, e.phase, got.busy, e.busy);
      end
    end
  end

  initial begin
    bus.tick = 1'b1;
    bus.req  = 4'd0;
`ifdef TLC_EMERGENCY_PREEMPT_EN
    bus.emerg_valid = 1'b0;
    bus.emerg_dir   = 2'd0;
`endif

    // Rest on m1, timer saturation, then a late request gaps out at once.
    do_reset();
    cyc(g(0), 2'd0, 1'b0, 257);
    bus.req = 4'b0010;
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.req = 4'b0000;
    cyc(y(0), 2'd0, 1'b1, 2);
    cyc(ALLR, 2'd0, 1'b1, 1);
    cyc(g(1), 2'd1, 1'b0, 5);

    // Gap-out to m3, then round-robin wrap m4 -> m2.
    do_reset();
    cyc(g(0), 2'd0, 1'b0, 3);
    bus.req = 4'b0100;
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.req = 4'b0000;
    cyc(y(0), 2'd0, 1'b1, 2);
    cyc(ALLR, 2'd0, 1'b1, 1);
    cyc(g(2), 2'd2, 1'b0, 1);
    bus.req = 4'b1010;
    cyc(g(2), 2'd2, 1'b0, 1);
    bus.req = 4'b0000;
    cyc(g(2), 2'd2, 1'b0, 2);
    cyc(y(2), 2'd2, 1'b1, 2);
    cyc(ALLR, 2'd2, 1'b1, 1);
    cyc(g(3), 2'd3, 1'b0, 4);
    cyc(y(3), 2'd3, 1'b1, 2);
    cyc(ALLR, 2'd3, 1'b1, 1);
    cyc(g(1), 2'd1, 1'b0, 6);

    // Max-out: m1 keeps its own request alive.
    do_reset();
    bus.req = 4'b0001;
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.req = 4'b0011;
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.req = 4'b0001;
    cyc(g(0), 2'd0, 1'b0, 8);
    cyc(y(0), 2'd0, 1'b1, 2);
    cyc(ALLR, 2'd0, 1'b1, 1);
    cyc(g(1), 2'd1, 1'b0, 1);
    bus.req = 4'b0000;
    cyc(g(1), 2'd1, 1'b0, 3);
    cyc(y(1), 2'd1, 1'b1, 2);
    cyc(ALLR, 2'd1, 1'b1, 1);
    cyc(g(0), 2'd0, 1'b0, 4);

    // Reset during yellow must also drop the latched request.
    do_reset();
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.req = 4'b0100;
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.req = 4'b0000;
    cyc(g(0), 2'd0, 1'b0, 2);
    cyc(y(0), 2'd0, 1'b1, 1);
    do_reset();
    cyc(g(0), 2'd0, 1'b0, 8);

`ifdef TLC_EMERGENCY_PREEMPT_EN
    do_reset();
    cyc(g(0), 2'd0, 1'b0, 1);
    bus.emerg_valid = 1'b1;
    bus.emerg_dir   = 2'd3;
    cyc(y(0), 2'd0, 1'b1, 2);
    cyc(ALLR, 2'd0, 1'b1, 1);
    cyc(g(3), 2'd3, 1'b0, 1);
    bus.req = 4'b0010;
    cyc(g(3), 2'd3, 1'b0, 1);
    bus.req = 4'b0000;
    cyc(g(3), 2'd3, 1'b0, 38);
    bus.emerg_valid = 1'b0;
    cyc(y(3), 2'd3, 1'b1, 2);
    cyc(ALLR, 2'd3, 1'b1, 1);
    cyc(g(1), 2'd1, 1'b0, 3);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      err_cnt++;
      $display("FAIL drain left %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
